trng_entropy_collector: RTL and testbench
=========================================

TRNG_ENTROPY_COLLECTOR -- requirements
Module: trng_entropy_collector

Interface
REQ-001 Parameter BLOCK_W, default 512, is the bits per assembled block and the conditioner input width.
REQ-002 Parameter RCT_CUTOFF, default 32, is the repetition-count limit; a run of this many identical samples is a failure.
REQ-003 Parameter APT_CUTOFF, default 400, is the adaptive-proportion limit; more than this many ones, or more than this many zeros, in one block is a failure.
REQ-004 Port clk, input, 1 bit, is the single clock; all state SHALL change on its rising edge only.
REQ-005 Port Resetn, input, 1 bit, is the asynchronous, active-low reset.
REQ-006 Port en, input, 1 bit, enables collection.
REQ-007 Port raw_bit, input, 1 bit, is the entropy sample; it arrives already synchronised to clk.
REQ-008 Port raw_valid, input, 1 bit, is the sample strobe; raw_bit is meaningful only when raw_valid is 1.
REQ-009 Port block_ready, input, 1 bit, is asserted by the downstream conditioner when it accepts a block.
REQ-010 Port clear_fail, input, 1 bit, is a one-cycle pulse that releases the FAIL state.
REQ-011 Port block_out, output, BLOCK_W bits, is the assembled block and feeds the SHA-256 data_in mux path.
REQ-012 Port block_valid, output, 1 bit, marks block_out as valid.
REQ-013 Port health_fail, output, 1 bit, is the latched health-test failure flag.
REQ-014 Port busy, output, 1 bit, is 1 in state COLLECT or FULL.

Function
REQ-015 The block SHALL implement exactly four states: IDLE, COLLECT, FULL and FAIL.
REQ-016 Transition IDLE->COLLECT SHALL occur on the clock edge where en=1; bit count and RCT run state SHALL be cleared at that edge.
REQ-017 In COLLECT, each accepted sample (raw_valid=1) SHALL update the block as block_out <= {block_out[BLOCK_W-2:0], raw_bit}, so the first sample ends up in the MSB.
REQ-018 Each accepted sample SHALL increment the bit counter and the ones counter (ones counter only when raw_bit=1).
REQ-019 RCT: the first sample after entering COLLECT sets the run length to 1; a sample equal to the previous one increments the run length; a different sample resets it to 1.
REQ-020 If the run length reaches RCT_CUTOFF, the next state SHALL be FAIL.
REQ-021 On the BLOCK_W-th accepted sample, if ones > APT_CUTOFF or (BLOCK_W - ones) > APT_CUTOFF, the next state SHALL be FAIL.
REQ-022 On the BLOCK_W-th accepted sample, if no failure is detected, the next state SHALL be FULL and block_valid SHALL be 1 from the following cycle.
REQ-023 If an RCT failure and block completion occur on the same sample, FAIL SHALL win and block_valid SHALL stay 0.
REQ-024 In FULL, block_out and block_valid SHALL be held stable, and raw samples SHALL be dropped and not counted.
REQ-025 In FULL, block_valid SHALL NOT drop until a handshake (block_valid=1 and block_ready=1 on a clock edge), regardless of en.
REQ-026 On the handshake edge, block_valid SHALL go to 0, the counters SHALL clear, and the next state SHALL be COLLECT if en=1, otherwise IDLE.
REQ-027 A sample presented on the handshake cycle SHALL be dropped.
REQ-028 block_ready asserted while block_valid=0 SHALL have no effect.
REQ-029 If en=0 in COLLECT, the next state SHALL be IDLE and the partial block SHALL be discarded: counters clear, block_out unchanged, no valid.
REQ-030 Latency: block_valid SHALL rise exactly 1 cycle after the edge that accepts the BLOCK_W-th sample.
REQ-031 Entering FAIL SHALL set health_fail=1 and block_valid=0; all samples are ignored while in FAIL.
REQ-032 FAIL SHALL persist until clear_fail=1, which SHALL move the state to IDLE, clear health_fail, and clear all counters.
REQ-033 All counters SHALL be sized to hold BLOCK_W without wrap; the bit counter SHALL never exceed BLOCK_W.

Reset
REQ-034 Resetn=0 SHALL immediately force, asynchronously: state IDLE, block_out=0, block_valid=0, health_fail=0, busy=0, and all counters and RCT run state to 0.
REQ-035 Reset asserted mid-COLLECT or mid-FULL SHALL discard the block, with no valid pulse after release.
REQ-036 Operation SHALL resume only on an en=1 edge after Resetn returns to 1.

Verification
REQ-037 en=1, 512 samples alternating 1,0,... -> block_valid=1 on the cycle after the 512th sample, block_out=512'hAAAA...A, health_fail=0.
REQ-038 block_ready held 0 for 20 cycles while further samples arrive -> block_out and block_valid stable, samples dropped; block_ready=1 -> valid drops the next cycle, and a fresh 512 samples are needed for the next block.
REQ-039 32 consecutive 1s from the start -> health_fail=1 the cycle after the 32nd sample, block_valid never asserted; clear_fail pulse -> IDLE, health_fail=0.
REQ-040 512 samples of repeating byte 0xFE (448 ones, max run 7) -> FAIL at completion, block_valid=0, health_fail=1.
REQ-041 en dropped after 300 samples, then re-enabled and 512 samples sent -> exactly one block produced, containing only the post-re-enable samples.
REQ-042 Resetn pulsed low while in FULL -> block_valid=0 and block_out=0 asynchronously; no block is produced after release until a new 512-sample fill.

Source files
------------

// File: rtl/trng_entropy_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : trng_entropy_collector_if
// Description : Bundle of the entropy collector's control, sample and block
//               handshake signals.
//               master : drives en, raw_bit, raw_valid, block_ready,
//                        clear_fail; observes block_out, block_valid,
//                        health_fail, busy
//               slave  : the collector itself (mirror directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface trng_entropy_collector_if #(
  parameter int BLOCK_W = 512
);
  logic               en;
  logic               raw_bit;
  logic               raw_valid;
  logic               block_ready;
  logic               clear_fail;
  logic [BLOCK_W-1:0] block_out;
  logic               block_valid;
  logic               health_fail;
  logic               busy;

  modport master (
    output en, raw_bit, raw_valid, block_ready, clear_fail,
    input  block_out, block_valid, health_fail, busy
  );

  modport slave (
    input  en, raw_bit, raw_valid, block_ready, clear_fail,
    output block_out, block_valid, health_fail, busy
  );
endinterface
`default_nettype wire

// File: rtl/trng_entropy_collector.sv
`default_nettype none
// ============================================================================
// Module      : trng_entropy_collector
// Description : Assembles raw entropy bits into BLOCK_W-bit blocks for the
//               conditioner while running repetition-count (RCT) and
//               adaptive-proportion (APT) health tests. A failing test
//               latches health_fail until clear_fail.
// Ports       : clk    - clock, all state changes on its rising edge
//               Resetn - asynchronous active-low reset
//               bus    - slave side of trng_entropy_collector_if
//                        (en, raw_bit/raw_valid in; block_out/block_valid
//                        out with block_ready handshake; clear_fail in;
//                        health_fail and busy status out)
// Revision    : 1.0 - initial release
// ============================================================================
module trng_entropy_collector #(
  parameter int BLOCK_W    = 512,
  parameter int RCT_CUTOFF = 32,
  parameter int APT_CUTOFF = 400
) (
  input  wire logic                  clk,
  input  wire logic                  Resetn,
  trng_entropy_collector_if.slave    bus
);

  localparam int CNT_W = $clog2(BLOCK_W + 1);
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

  localparam logic [CNT_W-1:0] C_BLOCK_W    = CNT_W'(BLOCK_W);
  localparam logic [CNT_W-1:0] C_APT_CUTOFF = CNT_W'(APT_CUTOFF);
  localparam logic [RUN_W-1:0] C_RCT_CUTOFF = RUN_W'(RCT_CUTOFF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [CNT_W-1:0]   ones_q,  ones_d;
  logic [RUN_W-1:0]   run_q,   run_d;
  logic               prev_q,  prev_d;
  logic               valid_q, valid_d;
  logic               fail_q,  fail_d;
  logic               busy_q,  busy_d;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_ones_inc;
  logic [CNT_W-1:0]   w_zeros;
  logic [RUN_W-1:0]   w_run_nxt;
  logic               w_last;
  logic               w_rct_fail;
  logic               w_apt_fail;

  always_comb begin
    state_d = state_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    run_d   = run_q;
    prev_d  = prev_q;
    valid_d = valid_q;
    fail_d  = fail_q;

    w_cnt_inc  = cnt_q + CNT_W'(1);
    w_ones_inc = ones_q + CNT_W'(bus.raw_bit);
    w_zeros    = C_BLOCK_W - w_ones_inc;
    // A zero run length marks the first sample since entering COLLECT.
    w_run_nxt  = (run_q == '0 || bus.raw_bit != prev_q) ? RUN_W'(1)
                                                         : run_q + RUN_W'(1);
    w_last     = (w_cnt_inc == C_BLOCK_W);
    w_rct_fail = (w_run_nxt == C_RCT_CUTOFF);
    w_apt_fail = w_last && ((w_ones_inc > C_APT_CUTOFF) ||
                            (w_zeros    > C_APT_CUTOFF));

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
          ones_d  = '0;
          run_d   = '0;
        end
      end

      ST_COLLECT: begin
        if (!bus.en) begin
          // Partial block is abandoned; block_out keeps its contents.
          state_d = ST_IDLE;
          cnt_d   = '0;
          ones_d  = '0;
          run_d   = '0;
        end else if (bus.raw_valid) begin
          block_d = {block_q[BLOCK_W-2:0], bus.raw_bit};
          cnt_d   = w_cnt_inc;
          ones_d  = w_ones_inc;
          run_d   = w_run_nxt;
          prev_d  = bus.raw_bit;
          // A health failure overrides block completion on the same sample.
          if (w_rct_fail || w_apt_fail) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            valid_d = 1'b0;
          end else if (w_last) begin
            state_d = ST_FULL;
            valid_d = 1'b1;
          end
        end
      end

      ST_FULL: begin
        // Samples are ignored here; only the handshake releases the block.
        if (valid_q && bus.block_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          ones_d  = '0;
          run_d   = '0;
          state_d = bus.en ? ST_COLLECT : ST_IDLE;
        end
      end

      ST_FAIL: begin
        if (bus.clear_fail) begin
          state_d = ST_IDLE;
          fail_d  = 1'b0;
          cnt_d   = '0;
          ones_d  = '0;
          run_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_COLLECT) || (state_d == ST_FULL);
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      block_q <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      run_q   <= '0;
      prev_q  <= 1'b0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.block_out   = block_q;
  assign bus.block_valid = valid_q;
  assign bus.health_fail = fail_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_entropy_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_trng_entropy_collector
// Description : Self-checking bench for trng_entropy_collector. Expected
//               blocks are queued when a fill is driven and compared when the
//               collector hands a block over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_entropy_collector;

  localparam int BLOCK_W = 512;

  logic clk;
  logic Resetn;

  trng_entropy_collector_if #(.BLOCK_W(BLOCK_W)) ifc ();

  trng_entropy_collector #(
    .BLOCK_W    (BLOCK_W),
    .RCT_CUTOFF (32),
    .APT_CUTOFF (400)
  ) u_dut (
    .clk    (clk),
    .Resetn (Resetn),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [BLOCK_W-1:0] exp_q [$];

  task automatic check_val(input string tag, input logic [BLOCK_W-1:0] obs,
                           input logic [BLOCK_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest queued block.
  always @(posedge clk) begin
    if (ifc.block_valid === 1'b1 && ifc.block_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_block", 1, 0);
      end else begin
        check_val("block_out", ifc.block_out, exp_q.pop_front());
      end
    end
  end

  // Drive pattern bits [511-start] downward, one sample per cycle.
  task automatic send_bits(input logic [BLOCK_W-1:0] pat, input int start,
                           input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      ifc.raw_valid = 1'b1;
      ifc.raw_bit   = pat[BLOCK_W-1-i];
    end
    @(negedge clk);
    ifc.raw_valid = 1'b0;
  endtask

  task automatic start_collect();
    @(negedge clk);
    ifc.en = 1'b1;
  endtask

  task automatic fill(input logic [BLOCK_W-1:0] pat, input bit push);
    send_bits(pat, 0, BLOCK_W - 1);
    check_val("valid_before_last", ifc.block_valid, 0);
    if (push) exp_q.push_back(pat);
    send_bits(pat, BLOCK_W - 1, 1);
    check_val("valid_after_last", ifc.block_valid, 1);
    check_val("block_out_full", ifc.block_out, pat);
    check_val("health_ok", ifc.health_fail, 0);
  endtask

  task automatic handshake(input bit with_sample);
    check_val("hs_valid_pre", ifc.block_valid, 1);
    @(negedge clk);
    ifc.block_ready = 1'b1;
    ifc.raw_valid   = with_sample;
    ifc.raw_bit     = 1'b0;
    @(negedge clk);
    ifc.block_ready = 1'b0;
    ifc.raw_valid   = 1'b0;
    check_val("hs_valid_drop", ifc.block_valid, 0);
  endtask

  task automatic clear_failure();
    @(negedge clk);
    ifc.en         = 1'b0;
    ifc.clear_fail = 1'b1;
    @(negedge clk);
    ifc.clear_fail = 1'b0;
    check_val("clear_health", ifc.health_fail, 0);
    check_val("clear_busy", ifc.busy, 0);
  endtask

  initial begin
    logic [BLOCK_W-1:0] p_alt, p_c5, p_3a, p_96, p_5c, p_fe, p_ones, p_misc;
    p_alt  = {(BLOCK_W/2){2'b10}};
    p_c5   = {(BLOCK_W/8){8'hC5}};
    p_3a   = {(BLOCK_W/8){8'h3A}};
    p_96   = {(BLOCK_W/8){8'h96}};
    p_5c   = {(BLOCK_W/8){8'h5C}};
    p_fe   = {(BLOCK_W/8){8'hFE}};
    p_ones = '1;
    p_misc = {(BLOCK_W/32){32'h1234_5678}};

    ifc.en = 1'b0; ifc.raw_bit = 1'b0; ifc.raw_valid = 1'b0;
    ifc.block_ready = 1'b0; ifc.clear_fail = 1'b0;
    Resetn = 1'b1;
    #3 Resetn = 1'b0;
    #1;
    check_val("rst_block_out", ifc.block_out, 0);
    check_val("rst_valid", ifc.block_valid, 0);
    check_val("rst_health", ifc.health_fail, 0);
    check_val("rst_busy", ifc.busy, 0);
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_without_en", ifc.busy, 0);

    // Alternating fill, then hold FULL while samples keep arriving.
    start_collect();
    @(negedge clk);
    check_val("busy_collect", ifc.busy, 1);
    fill(p_alt, 1'b1);
    send_bits(p_misc, 0, 20);
    check_val("hold_valid", ifc.block_valid, 1);
    check_val("hold_block", ifc.block_out, p_alt);
    check_val("hold_busy", ifc.busy, 1);
    handshake(1'b1);
    check_val("busy_after_hs", ifc.busy, 1);
    fill(p_c5, 1'b1);
    handshake(1'b0);
    @(negedge clk);
    ifc.en = 1'b0;
    @(negedge clk);

    // Repetition-count failure on 32 consecutive ones.
    start_collect();
    send_bits(p_ones, 0, 31);
    check_val("rct_health_31", ifc.health_fail, 0);
    send_bits(p_ones, 31, 1);
    check_val("rct_health_32", ifc.health_fail, 1);
    check_val("rct_valid", ifc.block_valid, 0);
    check_val("rct_busy", ifc.busy, 0);
    send_bits(p_alt, 0, 10);
    check_val("fail_sticky", ifc.health_fail, 1);
    clear_failure();

    // Adaptive-proportion failure: 448 ones in a block.
    start_collect();
    send_bits(p_fe, 0, BLOCK_W - 1);
    check_val("apt_health_511", ifc.health_fail, 0);
    send_bits(p_fe, BLOCK_W - 1, 1);
    check_val("apt_health_512", ifc.health_fail, 1);
    check_val("apt_valid", ifc.block_valid, 0);
    clear_failure();

    // Partial block discarded when en drops.
    start_collect();
    send_bits(p_c5, 0, 300);
    ifc.en = 1'b0;
    @(negedge clk);
    check_val("abort_busy", ifc.busy, 0);
    ifc.en = 1'b1;
    fill(p_3a, 1'b1);
    handshake(1'b0);
    check_val("one_block_only", exp_q.size(), 0);
    @(negedge clk);
    ifc.en = 1'b0;
    @(negedge clk);

    // Asynchronous reset while FULL.
    start_collect();
    fill(p_96, 1'b0);
    @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    check_val("async_valid", ifc.block_valid, 0);
    check_val("async_block", ifc.block_out, 0);
    check_val("async_busy", ifc.busy, 0);
    @(negedge clk);
    Resetn = 1'b1;
    ifc.en = 1'b0;
    ifc.block_ready = 1'b1;
    repeat (10) @(negedge clk);
    ifc.block_ready = 1'b0;
    check_val("post_rst_valid", ifc.block_valid, 0);
    check_val("post_rst_busy", ifc.busy, 0);
    start_collect();
    fill(p_5c, 1'b1);
    handshake(1'b0);

    repeat (2) @(negedge clk);
    check_val("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
